// File: rtl/shift_reg_ctrl.sv
// Serializes parallel words LSB first into the shift_reg_8bit serial_in/en pins.
// Adds a programmable idle gap between frames and supports synchronous abort.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             abort,
    output logic             sr_serial_in,
    output logic             sr_en,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_aborted
);

    localparam int CNT_W    = $clog2(WIDTH);
    localparam int GAP_W    = $clog2(GAP + 2);
    localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   hold_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;

    logic               accept_s;
    logic               last_shift_s;
    logic               gap_done_s;

    logic               tx_ready_r;
    logic               sr_en_r;
    logic               sr_serial_in_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               frame_aborted_r;

    logic               ready_s;
    logic               en_s;
    logic               bit_s;
    logic               busy_s;
    logic               done_s;
    logic               aborted_s;

    assign accept_s     = (state_r == S_IDLE) & tx_valid & tx_ready_r;
    assign last_shift_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign gap_done_s   = (gap_cnt_r == GAP_W'(0));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort in SHIFT or GAP always returns to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_SHIFT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (last_shift_s) begin
                    state_s = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_GAP: begin
                if (abort || gap_done_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_GAP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; abort suppresses the pending shift
    always_comb begin
        en_s      = 1'b0;
        bit_s     = 1'b0;
        aborted_s = 1'b0;
        case (state_r)
            S_SHIFT: begin
                en_s      = ~abort;
                bit_s     = ~abort & hold_r[cnt_r];
                aborted_s = abort;
            end
            default: begin
                en_s      = 1'b0;
                bit_s     = 1'b0;
                aborted_s = 1'b0;
            end
        endcase
        ready_s = (state_s == S_IDLE);
        busy_s  = (state_s != S_IDLE);
        // Last enable just went out and the sequencer has left SHIFT without abort
        done_s  = sr_en_r & (state_r != S_SHIFT);
    end

    // Word holding, bit counter and gap counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r    <= {WIDTH{1'b0}};
            cnt_r     <= CNT_W'(0);
            gap_cnt_r <= GAP_W'(0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        hold_r <= tx_data;
                    end
                    cnt_r <= CNT_W'(0);
                end
                S_SHIFT: begin
                    cnt_r     <= (abort || last_shift_s) ? CNT_W'(0) : cnt_r + CNT_W'(1);
                    gap_cnt_r <= GAP_W'(GAP_LOAD);
                end
                S_GAP: begin
                    if (!gap_done_s) begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                default: begin
                    cnt_r     <= CNT_W'(0);
                    gap_cnt_r <= GAP_W'(0);
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ready_r      <= 1'b1;
            sr_en_r         <= 1'b0;
            sr_serial_in_r  <= 1'b0;
            busy_r          <= 1'b0;
            frame_done_r    <= 1'b0;
            frame_aborted_r <= 1'b0;
        end else begin
            tx_ready_r      <= ready_s;
            sr_en_r         <= en_s;
            sr_serial_in_r  <= bit_s;
            busy_r          <= busy_s;
            frame_done_r    <= done_s;
            frame_aborted_r <= aborted_s;
        end
    end

    assign tx_ready      = tx_ready_r;
    assign sr_en         = sr_en_r;
    assign sr_serial_in  = sr_serial_in_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign frame_aborted = frame_aborted_r;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: three instances (GAP 0, 1, 3) share stimulus and are
// compared every cycle against a frame-timeline reference model.
module tb_shift_reg_ctrl;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       abort;

    logic rdy0, sin0, en0, busy0, done0, ab0;
    logic rdy1, sin1, en1, busy1, done1, ab1;
    logic rdy2, sin2, en2, busy2, done2, ab2;

    logic [7:0] sr_q1;

    int checks;
    int errors;
    int cyc;

    // Reference model: one frame record per instance, expressed as cycle numbers
    bit         f_v[3];
    int         f_s[3];
    logic [7:0] f_w[3];
    int         f_a[3];
    int         f_g[3];
    int         d_prev[3];
    int         d_cur[3];

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       abort;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[12];

    shift_reg_ctrl #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy0), .abort(abort), .sr_serial_in(sin0), .sr_en(en0),
        .busy(busy0), .frame_done(done0), .frame_aborted(ab0));

    shift_reg_ctrl #(.WIDTH(W), .GAP(1)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy1), .abort(abort), .sr_serial_in(sin1), .sr_en(en1),
        .busy(busy1), .frame_done(done1), .frame_aborted(ab1));

    shift_reg_ctrl #(.WIDTH(W), .GAP(3)) dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy2), .abort(abort), .sr_serial_in(sin2), .sr_en(en2),
        .busy(busy2), .frame_done(done2), .frame_aborted(ab2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural downstream register for the GAP=1 instance
    always @(posedge clk) begin
        if (en1) sr_q1 <= {sin1, sr_q1[7:1]};
    end

    function automatic int gap_of(input int i);
        case (i)
            0: return 0;
            1: return 1;
            default: return 3;
        endcase
    endfunction

    // Output vector layout: {tx_ready, sr_en, sr_serial_in, busy, frame_done, frame_aborted}
    function automatic logic [5:0] outs(input int i);
        case (i)
            0: return {rdy0, en0, sin0, busy0, done0, ab0};
            1: return {rdy1, en1, sin1, busy1, done1, ab1};
            default: return {rdy2, en2, sin2, busy2, done2, ab2};
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int idle_from(input int i);
        if (f_a[i] >= 0) return f_a[i] + 1;
        if (f_g[i] >= 0) return f_g[i] + 1;
        return f_s[i] + W + 1 + gap_of(i);
    endfunction

    function automatic logic [5:0] model_exp(input int i);
        logic [5:0] e;
        int s;
        int last_en;
        e = 6'b100000;
        s = f_s[i];
        if (f_v[i]) begin
            last_en = (f_a[i] >= 0) ? f_a[i] : s + W + 1;
            if (cyc >= s + 1 && cyc < idle_from(i)) begin
                e[5] = 1'b0;
                e[2] = 1'b1;
            end
            if (cyc >= s + 2 && cyc <= last_en) begin
                e[4] = 1'b1;
                e[3] = f_w[i][cyc - s - 2];
            end
            if (f_a[i] >= 0 && cyc == f_a[i] + 1) e[0] = 1'b1;
        end
        if (cyc == d_prev[i] || cyc == d_cur[i]) e[1] = 1'b1;
        return e;
    endfunction

    task automatic model_cycle(input int i);
        logic [5:0] e;
        int s;
        if (reset) begin
            f_v[i]    = 1'b0;
            d_prev[i] = -1;
            d_cur[i]  = -1;
        end
        e = model_exp(i);
        chk($sformatf("model_gap%0d", gap_of(i)), outs(i), e);
        s = f_s[i];
        if (!reset) begin
            if (tx_valid && e[5]) begin
                f_v[i] = 1'b1; f_s[i] = cyc; f_w[i] = tx_data;
                f_a[i] = -1;   f_g[i] = -1;
                d_prev[i] = d_cur[i];
                d_cur[i]  = cyc + W + 2;
            end else if (abort && f_v[i] && cyc < idle_from(i)) begin
                if (cyc >= s + 1 && cyc <= s + W) begin
                    f_a[i]   = cyc;
                    d_cur[i] = -1;
                end else if (cyc >= s + W + 1) begin
                    f_g[i] = cyc;
                end
            end
        end
    endtask

    task automatic step_neg();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) model_cycle(i);
    endtask

    task automatic step_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_();
        step_neg();
        step_pos();
    endtask

    task automatic settle();
        tx_valid = 1'b0;
        abort    = 1'b0;
        repeat (20) cycle_();
    endtask

    // Hold tx_valid and wait (bounded) for one acceptance by instance inst
    task automatic send(input logic [7:0] d, input int inst, output int acc);
        logic [5:0] o;
        tx_valid = 1'b1;
        tx_data  = d;
        acc      = -1;
        for (int t = 0; t < 40 && acc < 0; t++) begin
            step_neg();
            o = outs(inst);
            if (o[5]) acc = cyc;
            step_pos();
        end
        tx_valid = 1'b0;
        if (acc < 0) chk("send_timeout", 0, 1);
    endtask

    // Two words with tx_valid held high; measure accept spacing and enable runs
    task automatic run_hold(input logic [7:0] d0, input logic [7:0] d1, input int inst, input string tag);
        int acc[2];
        int n;
        int dones;
        int k;
        int ones1;
        int zeros;
        int ones2;
        bit en_h[40];
        logic [5:0] o;
        n = 0; dones = 0;
        tx_valid = 1'b1;
        tx_data  = d0;
        for (int t = 0; t < 40; t++) begin
            step_neg();
            o = outs(inst);
            en_h[t] = o[4];
            if (o[1]) dones++;
            if (o[5] && tx_valid && n < 2) begin
                acc[n] = cyc;
                n++;
            end
            step_pos();
            if (n == 1) tx_data = d1;
            if (n >= 2) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        chk({tag, "_accepts"}, n, 2);
        if (n == 2) chk({tag, "_accept_interval"}, acc[1] - acc[0], W + 1 + gap_of(inst));
        k = 0; ones1 = 0; zeros = 0; ones2 = 0;
        while (k < 40 && !en_h[k]) k++;
        while (k < 40 && en_h[k]) begin ones1++; k++; end
        while (k < 40 && !en_h[k]) begin zeros++; k++; end
        while (k < 40 && en_h[k]) begin ones2++; k++; end
        chk({tag, "_frame1_shifts"}, ones1, W);
        chk({tag, "_idle_between"}, zeros, gap_of(inst) + 1);
        chk({tag, "_frame2_shifts"}, ones2, W);
        chk({tag, "_done_pulses"}, dones, 2);
    endtask

    initial begin
        logic [7:0] w;
        logic [5:0] o;
        int acc;
        int seen;

        checks = 0; errors = 0; cyc = 0;
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_v[i] = 1'b0; f_s[i] = 0; f_w[i] = 8'h00; f_a[i] = -1; f_g[i] = -1;
            d_prev[i] = -1; d_cur[i] = -1;
        end

        w = 8'hA5;
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 6'b100000};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 6'b000100};
        for (int k = 2; k < 10; k++) tbl[k] = '{1'b0, 8'h00, 1'b0, {1'b0, 1'b1, w[k-2], 1'b1, 1'b0, 1'b0}};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 6'b100010};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 6'b100000};

        #1;
        step_neg();
        for (int i = 0; i < 3; i++) chk($sformatf("reset_state_%0d", i), outs(i), 6'b100000);
        step_pos();
        reset = 1'b0;

        // 0xA5 on the GAP=1 instance, cycle by cycle
        for (int r = 0; r < 12; r++) begin
            tx_valid = tbl[r].valid;
            tx_data  = tbl[r].data;
            abort    = tbl[r].abort;
            step_neg();
            chk($sformatf("table_row%0d", r), outs(1), tbl[r].exp);
            step_pos();
        end
        chk("register_A5", sr_q1, 8'hA5);
        settle();

        run_hold(8'h01, 8'hFF, 1, "hold_gap1");
        settle();
        run_hold(8'h3C, 8'hC3, 0, "b2b_gap0");
        settle();
        run_hold(8'h55, 8'hAA, 2, "hold_gap3");
        settle();

        // Abort on the 4th shift of 0xF0
        send(8'hF0, 1, acc);
        repeat (4) cycle_();
        abort = 1'b1;
        step_neg();
        o = outs(1);
        chk("abort4_en_before", o[4], 1);
        step_pos();
        abort = 1'b0;
        step_neg();
        o = outs(1);
        chk("abort4_en_after", o[4], 0);
        chk("abort4_pulse", o[0], 1);
        chk("abort4_ready", o[5], 1);
        step_pos();
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            step_neg();
            o = outs(1);
            if (o[1]) seen++;
            step_pos();
        end
        chk("abort4_no_done", seen, 0);
        settle();

        // Abort on the final shift (cnt==WIDTH-1): abort wins
        send(8'h96, 1, acc);
        repeat (7) cycle_();
        abort = 1'b1;
        step_neg();
        o = outs(1);
        chk("abort_last_en_before", o[4], 1);
        step_pos();
        abort = 1'b0;
        step_neg();
        o = outs(1);
        chk("abort_last_pulse", o[0], 1);
        chk("abort_last_en_after", o[4], 0);
        step_pos();
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            step_neg();
            o = outs(1);
            if (o[1]) seen++;
            step_pos();
        end
        chk("abort_last_no_done", seen, 0);
        settle();

        // Abort during the GAP=3 instance's gap
        send(8'h3C, 2, acc);
        repeat (8) cycle_();
        abort = 1'b1;
        step_neg();
        o = outs(2);
        chk("abort_gap_busy_before", o[2], 1);
        step_pos();
        abort = 1'b0;
        step_neg();
        o = outs(2);
        chk("abort_gap_ready", o[5], 1);
        chk("abort_gap_busy", o[2], 0);
        chk("abort_gap_no_abort_pulse", o[0], 0);
        step_pos();
        settle();

        // Asynchronous reset on the 3rd shift, then a clean frame
        send(8'h77, 1, acc);
        repeat (3) cycle_();
        #2;
        o = outs(1);
        chk("reset_mid_en_before", o[4], 1);
        reset = 1'b1;
        #1;
        chk("reset_mid_outputs", outs(1), 6'b100000);
        step_neg();
        step_pos();
        reset = 1'b0;
        cycle_();
        send(8'h5A, 1, acc);
        repeat (12) cycle_();
        chk("register_5A", sr_q1, 8'h5A);
        settle();

        // Random traffic with occasional abort and reset
        for (int t = 0; t < 1500; t++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            abort    = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            cycle_();
        end
        reset = 1'b0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
